// File: rtl/air_hockey_pkg.sv
// Shared constants, colours and puck state encoding for the air-hockey blocks.
package air_hockey_pkg;

  localparam int WIDTH    = 96;
  localparam int HEIGHT   = 64;
  localparam int PADDLE_H = 20;
  localparam int PADDLE_W = 3;

  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] WHITE = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_GOAL,
    ST_OVER
  } puck_state_t;

  // |a-b| <= lim, evaluated in 8-bit signed so small coordinates never wrap.
  function automatic logic within8(input logic [6:0] a, input logic [6:0] b,
                                   input logic [7:0] lim);
    logic signed [7:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d <= $signed(lim);
  endfunction

endpackage

// File: rtl/puck_collision.sv
// Combinational wall, paddle and goal detection on the current puck position.
module puck_collision #(
  parameter int WIDTH    = air_hockey_pkg::WIDTH,
  parameter int HEIGHT   = air_hockey_pkg::HEIGHT,
  parameter int PADDLE_H = air_hockey_pkg::PADDLE_H,
  parameter int PADDLE_W = air_hockey_pkg::PADDLE_W
) (
  input  logic [6:0] i_puckX,
  input  logic [6:0] i_puckY,
  input  logic       i_dxPos,
  input  logic       i_dyPos,
  input  logic [6:0] i_userX,
  input  logic [6:0] i_userY,
  input  logic [6:0] i_audioX,
  input  logic [6:0] i_audioY,
  output logic       o_flipX,
  output logic       o_flipY,
  output logic       o_goalL,
  output logic       o_goalR
);
  import air_hockey_pkg::*;

  localparam logic signed [7:0] C_XMAX = 8'(WIDTH - 1);
  localparam logic signed [7:0] C_YMAX = 8'(HEIGHT - 1);
  localparam logic signed [7:0] C_HW   = 8'(PADDLE_W / 2);
  localparam logic signed [7:0] C_YWIN = 8'(PADDLE_H / 2 + 1);

  logic signed [7:0] w_px, w_py, w_ux, w_ax;
  logic w_userYok, w_audioYok, w_userHit, w_audioHit;

  assign w_px = $signed({1'b0, i_puckX});
  assign w_py = $signed({1'b0, i_puckY});
  assign w_ux = $signed({1'b0, i_userX});
  assign w_ax = $signed({1'b0, i_audioX});

  assign w_userYok  = within8(i_puckY, i_userY, C_YWIN);
  assign w_audioYok = within8(i_puckY, i_audioY, C_YWIN);

  assign o_goalL = !i_dxPos && (w_px - 8'sd1 == 8'sd0);
  assign o_goalR =  i_dxPos && (w_px + 8'sd1 == C_XMAX);

  assign w_userHit  = !i_dxPos && (w_px - 8'sd1 == w_ux + C_HW + 8'sd1) && w_userYok;
  assign w_audioHit =  i_dxPos && (w_px + 8'sd1 == w_ax - C_HW - 8'sd1) && w_audioYok;

  assign o_flipX = w_userHit | w_audioHit;
  assign o_flipY = (!i_dyPos && (w_py - 8'sd1 == 8'sd0)) ||
                   ( i_dyPos && (w_py + 8'sd1 == C_YMAX));

endmodule

// File: rtl/air_hockey_puck.sv
// Puck engine: movement, bounces, goals, scoring and serve/pause/over sequencing.
module air_hockey_puck #(
  parameter int WIDTH       = air_hockey_pkg::WIDTH,
  parameter int HEIGHT      = air_hockey_pkg::HEIGHT,
  parameter int PADDLE_H    = air_hockey_pkg::PADDLE_H,
  parameter int PADDLE_W    = air_hockey_pkg::PADDLE_W,
  parameter int PAUSE_TICKS = 32,
  parameter int WIN_SCORE   = 7
) (
  input  logic        clkPaddle,
  input  logic        rst,
  input  logic        sw15,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  input  logic [6:0]  userPaddleX,
  input  logic [6:0]  userPaddleY,
  input  logic [6:0]  audioPaddleX,
  input  logic [6:0]  audioPaddleY,
  output logic [6:0]  puckX,
  output logic [6:0]  puckY,
  output logic        puckAppear,
  output logic [15:0] puck_col,
  output logic [3:0]  userScore,
  output logic [3:0]  audioScore,
  output logic        goalPulse,
  output logic        gameOver
);
  import air_hockey_pkg::*;

  localparam int               CNT_W  = $clog2(PAUSE_TICKS + 1);
  localparam logic [6:0]       C_CX   = 7'(WIDTH / 2);
  localparam logic [6:0]       C_CY   = 7'(HEIGHT / 2);
  localparam logic [3:0]       C_WIN  = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PAUSE_TICKS - 1);

  puck_state_t      r_state, w_stateN;
  logic [6:0]       r_puckX, r_puckY, w_puckXN, w_puckYN;
  logic             r_dxPos, r_dyPos, r_serveDir, w_dxPosN, w_dyPosN, w_serveDirN;
  logic [3:0]       r_userScore, r_audioScore, w_userScoreN, w_audioScoreN;
  logic             r_goalPulse, r_gameOver, w_goalPulseN, w_gameOverN;
  logic [CNT_W-1:0] r_cnt, w_cntN;
  logic             w_clr, w_flipX, w_flipY, w_goalL, w_goalR;

  assign w_clr = rst | ~sw15;

  puck_collision #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .PADDLE_H(PADDLE_H),
    .PADDLE_W(PADDLE_W)
  ) u_collision (
    .i_puckX (r_puckX),
    .i_puckY (r_puckY),
    .i_dxPos (r_dxPos),
    .i_dyPos (r_dyPos),
    .i_userX (userPaddleX),
    .i_userY (userPaddleY),
    .i_audioX(audioPaddleX),
    .i_audioY(audioPaddleY),
    .o_flipX (w_flipX),
    .o_flipY (w_flipY),
    .o_goalL (w_goalL),
    .o_goalR (w_goalR)
  );

  always_ff @(posedge clkPaddle) begin
    if (w_clr) begin
      r_state      <= ST_IDLE;
      r_puckX      <= C_CX;
      r_puckY      <= C_CY;
      r_dxPos      <= 1'b1;
      r_dyPos      <= 1'b1;
      r_serveDir   <= 1'b1;
      r_userScore  <= '0;
      r_audioScore <= '0;
      r_goalPulse  <= 1'b0;
      r_gameOver   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_stateN;
      r_puckX      <= w_puckXN;
      r_puckY      <= w_puckYN;
      r_dxPos      <= w_dxPosN;
      r_dyPos      <= w_dyPosN;
      r_serveDir   <= w_serveDirN;
      r_userScore  <= w_userScoreN;
      r_audioScore <= w_audioScoreN;
      r_goalPulse  <= w_goalPulseN;
      r_gameOver   <= w_gameOverN;
      r_cnt        <= w_cntN;
    end
  end

  always_comb begin
    w_stateN      = r_state;
    w_puckXN      = r_puckX;
    w_puckYN      = r_puckY;
    w_dxPosN      = r_dxPos;
    w_dyPosN      = r_dyPos;
    w_serveDirN   = r_serveDir;
    w_userScoreN  = r_userScore;
    w_audioScoreN = r_audioScore;
    w_goalPulseN  = 1'b0;
    w_gameOverN   = 1'b0;
    w_cntN        = r_cnt;
    unique case (r_state)
      ST_IDLE: w_stateN = ST_SERVE;
      ST_SERVE: begin
        w_puckXN = C_CX;
        w_puckYN = C_CY;
        w_dxPosN = r_serveDir;
        w_dyPosN = 1'b1;
        w_stateN = ST_PLAY;
      end
      ST_PLAY: begin
        // Goals take priority and freeze the position; otherwise flips feed the move.
        if (w_goalL) begin
          if (r_audioScore < C_WIN) w_audioScoreN = r_audioScore + 4'd1;
          w_serveDirN  = 1'b0;
          w_goalPulseN = 1'b1;
          w_cntN       = '0;
          w_stateN     = ST_GOAL;
        end else if (w_goalR) begin
          if (r_userScore < C_WIN) w_userScoreN = r_userScore + 4'd1;
          w_serveDirN  = 1'b1;
          w_goalPulseN = 1'b1;
          w_cntN       = '0;
          w_stateN     = ST_GOAL;
        end else begin
          w_dxPosN = r_dxPos ^ w_flipX;
          w_dyPosN = r_dyPos ^ w_flipY;
          w_puckXN = w_dxPosN ? r_puckX + 7'd1 : r_puckX - 7'd1;
          w_puckYN = w_dyPosN ? r_puckY + 7'd1 : r_puckY - 7'd1;
        end
      end
      ST_GOAL: begin
        w_puckXN = C_CX;
        w_puckYN = C_CY;
        if (r_cnt == C_LAST) begin
          w_cntN = '0;
          if (r_userScore == C_WIN || r_audioScore == C_WIN) begin
            w_stateN    = ST_OVER;
            w_gameOverN = 1'b1;
          end else begin
            w_stateN = ST_SERVE;
          end
        end else begin
          w_cntN = r_cnt + 1'b1;
        end
      end
      ST_OVER: begin
        w_puckXN    = C_CX;
        w_puckYN    = C_CY;
        w_gameOverN = 1'b1;
      end
      default: w_stateN = ST_IDLE;
    endcase
  end

  assign puckX      = r_puckX;
  assign puckY      = r_puckY;
  assign userScore  = r_userScore;
  assign audioScore = r_audioScore;
  assign goalPulse  = r_goalPulse;
  assign gameOver   = r_gameOver;
  assign puckAppear = within8(x, puckX, 8'd1) & within8(y, puckY, 8'd1);
  assign puck_col   = WHITE;

endmodule

// File: tb/tb_air_hockey_puck.sv
// Scoreboard bench: a behavioural game model predicts every tick; directed steps hit the key cases.
module tb_air_hockey_puck;

  logic       clkPaddle = 1'b0;
  logic       rst = 1'b1, sw15 = 1'b1;
  logic [6:0] x = '0, y = '0;
  logic [6:0] userPaddleX = 7'd5, userPaddleY = 7'd0;
  logic [6:0] audioPaddleX = 7'd81, audioPaddleY = 7'd0;
  logic [6:0] puckX, puckY;
  logic       puckAppear, goalPulse, gameOver;
  logic [15:0] puck_col;
  logic [3:0] userScore, audioScore;

  air_hockey_puck dut (
    .clkPaddle(clkPaddle), .rst(rst), .sw15(sw15), .x(x), .y(y),
    .userPaddleX(userPaddleX), .userPaddleY(userPaddleY),
    .audioPaddleX(audioPaddleX), .audioPaddleY(audioPaddleY),
    .puckX(puckX), .puckY(puckY), .puckAppear(puckAppear), .puck_col(puck_col),
    .userScore(userScore), .audioScore(audioScore),
    .goalPulse(goalPulse), .gameOver(gameOver)
  );

  always #5 clkPaddle = ~clkPaddle;

  typedef struct { int x, y, us, as, gp, go; } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;
  // model: state 0 IDLE 1 SERVE 2 PLAY 3 GOAL 4 OVER
  int m_st, m_x, m_y, m_dx, m_dy, m_srv, m_us, m_as, m_gp, m_go, m_cnt;
  bit u_track = 1, a_track = 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timed out", tag);
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int far_y(input int py);
    return py < 32 ? py + 32 : py - 32;
  endfunction

  task automatic model_step();
    m_gp = 0;
    if (rst || !sw15) begin
      m_st = 0; m_x = 48; m_y = 32; m_dx = 1; m_dy = 1; m_srv = 1;
      m_us = 0; m_as = 0; m_go = 0; m_cnt = 0;
    end else begin
      m_go = 0;
      case (m_st)
        0: m_st = 1;
        1: begin m_x = 48; m_y = 32; m_dx = m_srv; m_dy = 1; m_st = 2; end
        2: begin
          if (m_dx < 0 && m_x == 1) begin
            if (m_as < 7) m_as++;
            m_srv = -1; m_gp = 1; m_cnt = 0; m_st = 3;
          end else if (m_dx > 0 && m_x == 94) begin
            if (m_us < 7) m_us++;
            m_srv = 1; m_gp = 1; m_cnt = 0; m_st = 3;
          end else begin
            int ndx, ndy;
            ndx = m_dx; ndy = m_dy;
            // paddle face is one pixel beyond the paddle's half-width edge
            if (m_dx < 0 && m_x - 1 == int'(userPaddleX) + 2 && iabs(m_y - int'(userPaddleY)) <= 11) ndx = 1;
            if (m_dx > 0 && m_x + 1 == int'(audioPaddleX) - 2 && iabs(m_y - int'(audioPaddleY)) <= 11) ndx = -1;
            if (m_dy < 0 && m_y == 1) ndy = 1;
            if (m_dy > 0 && m_y == 62) ndy = -1;
            m_dx = ndx; m_dy = ndy; m_x += ndx; m_y += ndy;
          end
        end
        3: begin
          m_x = 48; m_y = 32;
          if (m_cnt == 31) begin
            m_cnt = 0;
            if (m_us == 7 || m_as == 7) begin m_st = 4; m_go = 1; end
            else m_st = 1;
          end else m_cnt++;
        end
        default: begin m_x = 48; m_y = 32; m_go = 1; end
      endcase
    end
  endtask

  task automatic tick();
    exp_t e;
    userPaddleY  = 7'(u_track ? m_y : far_y(m_y));
    audioPaddleY = 7'(a_track ? m_y : far_y(m_y));
    model_step();
    e.x = m_x; e.y = m_y; e.us = m_us; e.as = m_as; e.gp = m_gp; e.go = m_go;
    q.push_back(e);
    @(posedge clkPaddle);
    #1;
    e = q.pop_front();
    chk("puckX", 16'(puckX), 16'(e.x));
    chk("puckY", 16'(puckY), 16'(e.y));
    chk("userScore", 16'(userScore), 16'(e.us));
    chk("audioScore", 16'(audioScore), 16'(e.as));
    chk("goalPulse", 16'(goalPulse), 16'(e.gp));
    chk("gameOver", 16'(gameOver), 16'(e.go));
  endtask

  initial begin
    int n;
    bit hit;
    m_y = 0;
    // reset, then serve: IDLE, SERVE, first move
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("serve_x", 16'(puckX), 16'd49);
    chk("serve_y", 16'(puckY), 16'd33);
    chk("colour", puck_col, 16'hFFFF);

    // puckAppear window around the puck
    for (int d = -2; d <= 2; d++) begin
      x = 7'(49 + d); y = 7'd34;
      #1;
      chk("appear", 16'(puckAppear), 16'(iabs(d) <= 1));
    end
    x = 7'd49; y = 7'd31;
    #1;
    chk("appear_y", 16'(puckAppear), 16'd0);

    // corner bounce against the audio paddle at the bottom wall
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_x == 78 && m_y == 62) hit = 1; else tick();
    end
    if (!hit) timeout_fail("corner_wait");
    tick();
    chk("corner_x", 16'(puckX), 16'd77);
    chk("corner_y", 16'(puckY), 16'd61);

    // tracked rally: paddles always intercept
    repeat (300) tick();
    chk("rally_us", 16'(userScore), 16'd0);
    chk("rally_as", 16'(audioScore), 16'd0);

    // user paddle misses: left goal
    u_track = 0;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      if (m_gp == 1) hit = 1;
    end
    if (!hit) timeout_fail("goalL_wait");
    chk("goalL_pulse", 16'(goalPulse), 16'd1);
    chk("goalL_as", 16'(audioScore), 16'd1);
    chk("goalL_x", 16'(puckX), 16'd1);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (puckX == 7'd48 && puckY == 7'd32 && !goalPulse) n++;
    end
    chk("pause_ticks", 16'(n), 16'd32);
    tick();
    tick();
    chk("serve_left", 16'(puckX), 16'd47);

    // audio paddle misses until user wins
    u_track = 1; a_track = 0;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick();
      if (m_go == 1) hit = 1;
    end
    if (!hit) timeout_fail("over_wait");
    chk("over_flag", 16'(gameOver), 16'd1);
    chk("over_us", 16'(userScore), 16'd7);
    chk("over_as", 16'(audioScore), 16'd1);
    repeat (20) tick();
    chk("frozen_x", 16'(puckX), 16'd48);

    // game enable low clears like reset
    sw15 = 1'b0;
    tick();
    chk("clr_us", 16'(userScore), 16'd0);
    chk("clr_go", 16'(gameOver), 16'd0);
    sw15 = 1'b1;
    tick(); tick();

    // reset arriving during the goal pause
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      if (m_gp == 1) hit = 1;
    end
    if (!hit) timeout_fail("goalR_wait");
    chk("goalR_us", 16'(userScore), 16'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_gp", 16'(goalPulse), 16'd0);
    chk("rst_us", 16'(userScore), 16'd0);
    chk("rst_x", 16'(puckX), 16'd48);
    rst = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
